// File: rtl/rf_pkg.sv
// Shared register-file types and widths for the write-back path.
package rf_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO for long-latency write-back results; pushes are ignored when full,
// pops ignored when empty. A same-cycle pop never frees the slot for that cycle's push.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t     r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push;
  logic        w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign empty  = (r_wptr == r_rptr);
  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign dout   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the register-file write port between the ALU (priority) and queued LSU/MDU results,
// and stalls issue on hazards against outstanding long-latency writes or when the queue starves.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  input  logic                  issue_long,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  stall,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t         w_push_req;
  wb_req_t         w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_alu_win;
  logic            w_pop;
  logic            w_lsu_wr;
  logic            w_throttle;
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [SW-1:0]   r_starve;

  assign w_push_req = '{rd: lsu_rd, data: lsu_data};

  rf_wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (lsu_valid),
    .din   (w_push_req),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign lsu_ready = !w_full;

  // An ALU write to x0 is a no-op and leaves the port free for the queue.
  assign w_alu_win = alu_valid && (alu_rd != '0);
  assign w_pop     = !w_alu_win && !w_empty;
  assign w_lsu_wr  = w_pop && (w_head.rd != '0);

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_alu_win) begin
      rf_wen   = 1'b1;
      rf_waddr = alu_rd;
      rf_wdata = alu_data;
    end else if (w_lsu_wr) begin
      rf_wen   = 1'b1;
      rf_waddr = w_head.rd;
      rf_wdata = w_head.data;
    end
  end

  assign w_throttle = (r_starve >= SW'(STARVE_MAX));
  assign stall = issue_valid &&
                 (r_busy[issue_rs1] || r_busy[issue_rs2] || r_busy[issue_rd] || w_throttle);

  // Clear first so a same-register set in the same cycle wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_lsu_wr) w_busy_nxt[w_head.rd] = 1'b0;
    if (issue_valid && issue_long && !stall && (issue_rd != '0))
      w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy   <= '0;
      r_starve <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (!w_throttle)
        r_starve <= r_starve + SW'(1);
    end
  end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler.
module tb_rf_wb_scheduler;
  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        stall;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  rf_wb_scheduler #(.XLEN(32), .QDEPTH(4), .STARVE_MAX(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_long  (issue_long),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .stall       (stall),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge; checks happen 2 units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input string tag, input logic wen, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wen"}, 32'(rf_wen), 32'(wen));
    if (wen) begin
      chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
      chk({tag, "_data"}, rf_wdata, d);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask

  initial begin
    idle();
    reset = 0;
    repeat (3) tick();
    #1;
    chk("rst_ready", 32'(lsu_ready), 32'd1);
    chk("rst_wen",   32'(rf_wen),    32'd0);
    chk("rst_waddr", 32'(rf_waddr),  32'd0);
    chk("rst_wdata", rf_wdata,       32'd0);
    chk("rst_stall", 32'(stall),     32'd0);
    reset = 1;
    tick();

    // Reset release: plain issue not stalled.
    issue_valid = 1; issue_rs1 = 5; issue_rs2 = 6; issue_rd = 1;
    #1;
    chk("rel_stall", 32'(stall), 32'd0);
    chk("rel_ready", 32'(lsu_ready), 32'd1);
    chk("rel_wen", 32'(rf_wen), 32'd0);
    tick();
    idle();

    // ALU priority over a concurrently queued LSU result.
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA5A5_A5A5;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h11;
    #1;
    wb("prio_c1", 1, 3, 32'hA5A5_A5A5);
    tick();
    idle();
    #1;
    wb("prio_c2", 1, 7, 32'h11);
    tick();
    #1;
    wb("prio_c3", 0, 0, 0);

    // RAW hazard against an outstanding long-latency write.
    issue_valid = 1; issue_long = 1; issue_rd = 9; issue_rs1 = 1; issue_rs2 = 2;
    #1;
    chk("haz_issue", 32'(stall), 32'd0);
    tick();
    issue_long = 0; issue_rd = 10; issue_rs1 = 9; issue_rs2 = 0;
    #1;
    chk("haz_raw1", 32'(stall), 32'd1);
    tick();
    #1;
    chk("haz_raw2", 32'(stall), 32'd1);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    lsu_valid = 0;
    #1;
    wb("haz_pop", 1, 9, 32'h99);
    chk("haz_nobypass", 32'(stall), 32'd1);
    tick();
    #1;
    chk("haz_release", 32'(stall), 32'd0);
    idle();

    // FIFO fill behind a continuous ALU stream, then drain with a wrap push.
    alu_valid = 1; alu_rd = 1; alu_data = 32'h100;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1; lsu_rd = 5'(11 + i); lsu_data = 32'h20 + i;
      #1;
      chk("fill_ready", 32'(lsu_ready), 32'd1);
      tick();
    end
    lsu_valid = 0;
    #1;
    chk("full_ready", 32'(lsu_ready), 32'd0);
    wb("full_alu", 1, 1, 32'h100);
    alu_valid = 0;
    #1;
    wb("drain0", 1, 11, 32'h20);
    chk("drain0_ready", 32'(lsu_ready), 32'd0);
    tick();
    #1;
    wb("drain1", 1, 12, 32'h21);
    chk("drain1_ready", 32'(lsu_ready), 32'd1);
    tick();
    #1;
    wb("drain2", 1, 13, 32'h22);
    tick();
    lsu_valid = 1; lsu_rd = 15; lsu_data = 32'h30;
    #1;
    wb("drain3", 1, 14, 32'h23);
    tick();
    lsu_valid = 0;
    #1;
    wb("wrap", 1, 15, 32'h30);
    tick();
    #1;
    wb("drained", 0, 0, 0);

    // Starvation throttle.
    alu_valid = 1; alu_rd = 2; alu_data = 32'h5;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'h77;
    tick();
    lsu_valid = 0;
    issue_valid = 1; issue_rs1 = 20; issue_rs2 = 21; issue_rd = 22;
    for (int k = 1; k <= 8; k++) begin
      tick();
      #1;
      chk($sformatf("starve%0d", k), 32'(stall), (k >= 8) ? 32'd1 : 32'd0);
    end
    alu_valid = 0;
    #1;
    wb("starve_pop", 1, 12, 32'h77);
    chk("starve_hold", 32'(stall), 32'd1);
    tick();
    #1;
    chk("starve_clear", 32'(stall), 32'd0);
    idle();

    // rd=0 LSU result pops without writing.
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD;
    tick();
    lsu_valid = 0;
    #1;
    wb("lsu_x0", 0, 0, 0);
    chk("lsu_x0_addr", 32'(rf_waddr), 32'd0);
    tick();

    // ALU write to x0 lets the queue drain.
    lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h55;
    tick();
    lsu_valid = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    #1;
    wb("alu_x0", 1, 5, 32'h55);
    tick();
    idle();

    // Async reset with queued entries and busy[4] set.
    issue_valid = 1; issue_long = 1; issue_rd = 4; issue_rs1 = 0; issue_rs2 = 0;
    tick();
    idle();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1; lsu_rd = 5'(16 + i); lsu_data = 32'h40 + i;
      tick();
    end
    idle();
    issue_valid = 1; issue_rs1 = 4;
    #1;
    chk("pre_rst_busy", 32'(stall), 32'd1);
    issue_valid = 0;
    #1;
    reset = 0;
    #1;
    chk("arst_wen",   32'(rf_wen),    32'd0);
    chk("arst_ready", 32'(lsu_ready), 32'd1);
    tick();
    tick();
    reset = 1;
    issue_valid = 1; issue_rs1 = 4; issue_rs2 = 0; issue_rd = 0;
    #1;
    chk("post_rst_busy", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("post_rst_wen%0d", i), 32'(rf_wen), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler for the 32×32 integer register file. It shares the file's single write port between the single-cycle ALU write-back path and the long-latency LSU/MDU result path. LSU results are buffered in a small FIFO. A per-register busy scoreboard stalls issue on RAW/WAW hazards against outstanding long-latency writes. It sits between execute/memory and the register file and drives that file's write enable, write address and write data.

## Interface
Parameters:
- XLEN, 32, data width
- QDEPTH, 4, LSU result FIFO depth (power of two, ≥2)
- STARVE_MAX, 8, consecutive denied cycles before issue is throttled

Ports (reset: reset, asynchronous, active-low; clock clk):
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result writes this cycle (cannot be back-pressured)
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU/MDU result offered
- lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready
- lsu_rd  in  5  LSU destination
- lsu_data  in  XLEN  LSU result
- issue_valid  in  1  decode presents an instruction
- issue_long  in  1  instruction's result returns via LSU path
- issue_rd, issue_rs1, issue_rs2  in  5 each  decoded register addresses
- stall  out  1  issue must hold this cycle
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data

## Operation
- Arbitration is fixed-priority and combinational:
  - alu_valid && alu_rd≠0: ALU owns the port.
  - Else, FIFO non-empty: pop the head and write it.
  - Else: rf_wen=0.
- An ALU write with rd=0 is dropped and does not occupy the port; the FIFO may drain that cycle.
- LSU writes with rd=0 are accepted into the FIFO and popped, but rf_wen stays 0 and no busy bit is cleared.
- FIFO: lsu_ready = !full. A push and a pop may occur in the same cycle, including when full: pop frees a slot next cycle only, so lsu_ready stays 0 that cycle. Pointers wrap modulo QDEPTH.
- Scoreboard busy[31:1] (busy[0] is hardwired 0):
  - Set: issue_valid && issue_long && !stall && issue_rd≠0 sets busy[issue_rd].
  - Clear: an LSU pop with rd≠0 clears busy[rd].
  - Same-register set and clear in one cycle: set wins.
- stall = issue_valid && (busy[rs1] || busy[rs2] || busy[rd] || throttle).
  - Busy on rd covers WAW. This also guarantees the ALU never targets a register with a pending LSU write.
- Starvation: counter starve increments each cycle the FIFO is non-empty and not popped. It resets to 0 on a pop or when the FIFO is empty. throttle = (starve ≥ STARVE_MAX). throttle holds issue until a pop occurs. The counter saturates at STARVE_MAX.
- Reset mid-operation drops all queued LSU results and clears all busy bits. The upstream pipeline is flushed by the same reset.

## Timing
- ALU path has zero latency: rf_* reflect alu_* in the same cycle.
- LSU path latency: a result accepted at edge N is writable in cycle N+1 at the earliest.
- Busy set at an issue edge becomes visible to stall in the next cycle.
- Busy clear at a pop edge releases stall in the next cycle. There is no same-cycle bypass.
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, stall=0, lsu_ready=1, FIFO empty, busy=0, starve=0.
- The register file samples rf_* on the same posedge clk. rf_* must be glitch-free settled combinational outputs of registered state plus alu_* only.

## Structure
- Shared package rf_pkg: XLEN, NREG=32, REG_ADDR_W=5, and a wb_req_t struct {rd, data}.
- One sub-module, rf_wb_fifo: parameterised synchronous FIFO with full/empty. It is instantiated once.
- Scoreboard, arbiter and starvation counter live in the top.

## Test plan
- Reset release: after reset, lsu_ready=1, rf_wen=0, stall=0. Issue of rs1=5, rs2=6 is not stalled.
- ALU priority: alu_valid rd=3 data=0xA5A5A5A5 in the same cycle as an LSU result rd=7 data=0x11 queued.
  - Cycle 1: write x3=0xA5A5A5A5.
  - Cycle 2: write x7=0x11.
- Hazard: issue_long rd=9, then next-cycle issue with rs1=9 → stall=1. Stall persists until the LSU rd=9 write pops, then drops 0 the following cycle.
- FIFO full/wrap:
  - With alu_valid held high, push 4 LSU results → lsu_ready=0.
  - Release the ALU → the 4 results write in order over 4 cycles. A push concurrent with the final pop lands correctly after pointer wrap.
- Starvation: FIFO holds 1 entry and alu_valid rd≠0 is held high → after 8 denied cycles, stall=1 for any issue_valid. throttle clears the cycle after the pop.
- rd=0 and async reset: LSU rd=0 pop gives rf_wen=0. Asserting reset with 3 queued entries and busy[4] set → all cleared, no write occurs after release.
